// File: rtl/div_result_bcd.sv
// div_result_bcd
// Downstream stage of the sequential restoring divider. On the rising edge of
// the divider's done flag it captures quotient and remainder, converts both
// to packed BCD with parallel shift-add-3 (double-dabble) engines (one bit per
// cycle), then offers the results over a valid/ready handshake.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   done_in    divider done flag (only its rising edge is used)
//   quo_in     divider quotient, sampled on done_in rising edge
//   rem_in     divider remainder, sampled on done_in rising edge
//   quo_bcd    packed BCD quotient, most significant digit in top nibble
//   rem_bcd    packed BCD remainder, same packing
//   bcd_valid  quo_bcd/rem_bcd hold a completed conversion
//   bcd_ready  consumer accepts the results (only looked at in HOLD)
//   busy       high while converting or holding a result
//   overrun    one-cycle pulse for every done_in rising edge that is dropped
module div_result_bcd #(
    parameter int DATA_WIDTH = 8,
    parameter int DIGITS     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  done_in,
    input  logic [DATA_WIDTH-1:0] quo_in,
    input  logic [DATA_WIDTH-1:0] rem_in,
    output logic [4*DIGITS-1:0]   quo_bcd,
    output logic [4*DIGITS-1:0]   rem_bcd,
    output logic                  bcd_valid,
    input  logic                  bcd_ready,
    output logic                  busy,
    output logic                  overrun
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

    state_t                state_reg, state_next;
    logic                  done_prev_reg;
    logic [DATA_WIDTH-1:0] quo_sh_reg, quo_sh_next;
    logic [DATA_WIDTH-1:0] rem_sh_reg, rem_sh_next;
    logic [BCD_W-1:0]      quo_acc_reg, quo_acc_next;
    logic [BCD_W-1:0]      rem_acc_reg, rem_acc_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [BCD_W-1:0]      quo_bcd_reg, quo_bcd_next;
    logic [BCD_W-1:0]      rem_bcd_reg, rem_bcd_next;
    logic                  valid_reg, valid_next;
    logic                  busy_reg, busy_next;
    logic                  overrun_reg, overrun_next;

    logic                  cap;
    logic [BCD_W-1:0]      quo_adj, rem_adj;
    logic [BCD_W-1:0]      quo_acc_shift, rem_acc_shift;

    // Add-3 correction: every nibble >= 5 is pre-corrected from the current
    // accumulator value so that the following doubling carries into the next
    // decimal digit correctly.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign quo_adj[4*gi +: 4] = (quo_acc_reg[4*gi +: 4] >= 4'd5)
                                        ? quo_acc_reg[4*gi +: 4] + 4'd3
                                        : quo_acc_reg[4*gi +: 4];
            assign rem_adj[4*gi +: 4] = (rem_acc_reg[4*gi +: 4] >= 4'd5)
                                        ? rem_acc_reg[4*gi +: 4] + 4'd3
                                        : rem_acc_reg[4*gi +: 4];
        end
    endgenerate

    // {acc, sh} << 1: MSB of the binary shifter enters bit 0 of the
    // accumulator; the accumulator's top bit falls off (never set when
    // 10^DIGITS covers the input range).
    assign quo_acc_shift = {quo_adj[BCD_W-2:0], quo_sh_reg[DATA_WIDTH-1]};
    assign rem_acc_shift = {rem_adj[BCD_W-2:0], rem_sh_reg[DATA_WIDTH-1]};

    assign cap = done_in & ~done_prev_reg;

    always_comb begin
        state_next   = state_reg;
        quo_sh_next  = quo_sh_reg;
        rem_sh_next  = rem_sh_reg;
        quo_acc_next = quo_acc_reg;
        rem_acc_next = rem_acc_reg;
        cnt_next     = cnt_reg;
        quo_bcd_next = quo_bcd_reg;
        rem_bcd_next = rem_bcd_reg;
        valid_next   = valid_reg;
        busy_next    = busy_reg;
        // Any capture edge that arrives outside IDLE is dropped, including the
        // HOLD->IDLE handshake cycle.
        overrun_next = cap && (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (cap) begin
                    quo_sh_next  = quo_in;
                    rem_sh_next  = rem_in;
                    quo_acc_next = '0;
                    rem_acc_next = '0;
                    cnt_next     = CNT_W'(DATA_WIDTH);
                    busy_next    = 1'b1;
                    state_next   = CONVERT;
                end
            end
            CONVERT: begin
                quo_acc_next = quo_acc_shift;
                rem_acc_next = rem_acc_shift;
                quo_sh_next  = quo_sh_reg << 1;
                rem_sh_next  = rem_sh_reg << 1;
                cnt_next     = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    quo_bcd_next = quo_acc_shift;
                    rem_bcd_next = rem_acc_shift;
                    valid_next   = 1'b1;
                    state_next   = HOLD;
                end
            end
            HOLD: begin
                if (valid_reg && bcd_ready) begin
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            done_prev_reg <= 1'b0;
            quo_sh_reg    <= '0;
            rem_sh_reg    <= '0;
            quo_acc_reg   <= '0;
            rem_acc_reg   <= '0;
            cnt_reg       <= '0;
            quo_bcd_reg   <= '0;
            rem_bcd_reg   <= '0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            done_prev_reg <= done_in;
            quo_sh_reg    <= quo_sh_next;
            rem_sh_reg    <= rem_sh_next;
            quo_acc_reg   <= quo_acc_next;
            rem_acc_reg   <= rem_acc_next;
            cnt_reg       <= cnt_next;
            quo_bcd_reg   <= quo_bcd_next;
            rem_bcd_reg   <= rem_bcd_next;
            valid_reg     <= valid_next;
            busy_reg      <= busy_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign quo_bcd   = quo_bcd_reg;
    assign rem_bcd   = rem_bcd_reg;
    assign bcd_valid = valid_reg;
    assign busy      = busy_reg;
    assign overrun   = overrun_reg;
endmodule

// File: tb/tb_div_result_bcd.sv
// Testbench for div_result_bcd: directed vectors with hand-computed BCD
// results, latency, backpressure, drop/overrun and async reset checks.
module tb_div_result_bcd;
    logic        clk;
    logic        rst;
    logic        done_in;
    logic [7:0]  quo_in;
    logic [7:0]  rem_in;
    logic [11:0] quo_bcd;
    logic [11:0] rem_bcd;
    logic        bcd_valid;
    logic        bcd_ready;
    logic        busy;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int ov_count = 0;
    int conv_count = 0;
    logic valid_prev = 1'b0;

    div_result_bcd #(.DATA_WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_in   (done_in),
        .quo_in    (quo_in),
        .rem_in    (rem_in),
        .quo_bcd   (quo_bcd),
        .rem_bcd   (rem_bcd),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts overrun-high cycles and bcd_valid rising edges.
    always @(negedge clk) begin
        if (overrun) ov_count++;
        if (bcd_valid && !valid_prev) conv_count++;
        valid_prev = bcd_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, obs);
        end
    endtask

    // Starts a conversion at the current negedge and waits for bcd_valid.
    // hold=1 keeps done_in high; inject_at>0 pulses a second done_in edge
    // (with different operands) at that cycle count.
    task automatic run_conv(input logic [7:0] q, input logic [7:0] r,
                            input logic [11:0] exp_q, input logic [11:0] exp_r,
                            input bit hold, input int inject_at);
        int k;
        bit all_busy;
        k = 0;
        all_busy = 1'b1;
        done_in = 1'b1;
        quo_in  = q;
        rem_in  = r;
        while (k < 20 && !bcd_valid) begin
            @(negedge clk);
            k++;
            if (!busy) all_busy = 1'b0;
            if (!hold && k == 1) done_in = 1'b0;
            if (inject_at > 0 && k == inject_at) begin
                done_in = 1'b1;
                quo_in  = 8'd200;
                rem_in  = 8'd77;
            end
            if (inject_at > 0 && k == inject_at + 1) done_in = 1'b0;
        end
        check($sformatf("latency_%0d_%0d", q, r), k, 9);
        check($sformatf("busy_during_%0d_%0d", q, r), all_busy, 1);
        check($sformatf("quo_bcd_%0d", q), quo_bcd, exp_q);
        check($sformatf("rem_bcd_%0d", r), rem_bcd, exp_r);
    endtask

    task automatic handshake(input logic [11:0] exp_q, input logic [11:0] exp_r);
        bcd_ready = 1'b1;
        @(negedge clk);
        bcd_ready = 1'b0;
        check("hs_valid", bcd_valid, 0);
        check("hs_busy", busy, 0);
        check("hs_quo_kept", quo_bcd, exp_q);
        check("hs_rem_kept", rem_bcd, exp_r);
    endtask

    initial begin
        int ov0;
        int cv0;
        bit stable;
        rst       = 1'b0;
        done_in   = 1'b0;
        quo_in    = '0;
        rem_in    = '0;
        bcd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_quo", quo_bcd, 0);
        check("rst_rem", rem_bcd, 0);
        check("rst_valid", bcd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 200/7
        run_conv(8'd28, 8'd4, 12'h028, 12'h004, 1'b0, 0);
        handshake(12'h028, 12'h004);

        // Boundaries
        run_conv(8'd255, 8'd0, 12'h255, 12'h000, 1'b0, 0);
        handshake(12'h255, 12'h000);
        run_conv(8'd99, 8'd100, 12'h099, 12'h100, 1'b0, 0);

        // Backpressure: 20 cycles with bcd_ready low
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bcd_valid || quo_bcd !== 12'h099 || rem_bcd !== 12'h100) stable = 1'b0;
        end
        check("backpressure_stable", stable, 1);
        handshake(12'h099, 12'h100);

        // done_in held high for 30 cycles
        ov0 = ov_count;
        cv0 = conv_count;
        run_conv(8'd17, 8'd3, 12'h017, 12'h003, 1'b1, 0);
        handshake(12'h017, 12'h003);
        repeat (20) @(negedge clk);
        done_in = 1'b0;
        repeat (15) @(negedge clk);
        check("held_one_conv", conv_count - cv0, 1);
        check("held_no_overrun", ov_count - ov0, 0);
        check("held_idle_valid", bcd_valid, 0);

        // Edge dropped during CONVERT
        ov0 = ov_count;
        run_conv(8'd50, 8'd9, 12'h050, 12'h009, 1'b0, 3);
        check("convert_drop_overrun", ov_count - ov0, 1);

        // Edge dropped during HOLD
        ov0 = ov_count;
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_drop_overrun", ov_count - ov0, 1);
        check("hold_drop_valid", bcd_valid, 1);
        check("hold_drop_quo", quo_bcd, 12'h050);
        check("hold_drop_rem", rem_bcd, 12'h009);
        handshake(12'h050, 12'h009);

        // Async reset 4 cycles into CONVERT
        done_in = 1'b1;
        quo_in  = 8'd123;
        rem_in  = 8'd45;
        @(negedge clk);
        done_in = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_quo", quo_bcd, 0);
        check("async_rst_rem", rem_bcd, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", bcd_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_conv(8'd42, 8'd7, 12'h042, 12'h007, 1'b0, 0);
        handshake(12'h042, 12'h007);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
